// File: rtl/noc_rr_pkt_mux_if.sv
// noc_rr_pkt_mux_if: bundles the flit handshake between upstream input buffers, the N:1 output
// mux and the downstream link.
//   idata/ivalid/ivch : flattened per-port input flits, valid and VC id (port k at slice k)
//   iready            : per-port accept returned upstream
//   odata/ovalid/ovch : registered output flit, valid and VC id
//   oready            : downstream accept
//   grant/locked      : current owner/winner (one-hot) and wormhole-lock status
// Modports: slave = mux side, master = environment driving the inputs and sinking the output.
interface noc_rr_pkt_mux_if #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned DATAW = 66,
    parameter int unsigned VCHW  = 2
);
    logic [NPORT*DATAW-1:0] idata;
    logic [NPORT-1:0]       ivalid;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT-1:0]       iready;
    logic [DATAW-1:0]       odata;
    logic                   ovalid;
    logic [VCHW-1:0]        ovch;
    logic                   oready;
    logic [NPORT-1:0]       grant;
    logic                   locked;

    modport master (
        output idata, ivalid, ivch, oready,
        input  iready, odata, ovalid, ovch, grant, locked
    );

    modport slave (
        input  idata, ivalid, ivch, oready,
        output iready, odata, ovalid, ovch, grant, locked
    );
endinterface

// File: rtl/noc_rr_pkt_mux.sv
// noc_rr_pkt_mux: N:1 packet-aware output multiplexer for the router output stage.
// Round-robin arbitration among NPORT inputs; the winner keeps the output (wormhole lock) from
// its HEAD/DATA flit until its TAIL flit is accepted. The output is a single register stage
// with ready/valid backpressure.
// Ports:
//   clk   : system clock, rising edge
//   rst_  : asynchronous active-low reset
//   bus   : noc_rr_pkt_mux_if.slave (input flits, per-port ready, output flit, grant, locked)
// Optional (macro NOC_MUX_STATS_EN):
//   oflit_cnt : count of output handshakes, wraps at 2^32
//   opkt_cnt  : count of output handshakes carrying a TAIL flit, wraps at 2^32
// Flit type field is idata[DATAW-1:DATAW-2]: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL.
module noc_rr_pkt_mux #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned DATAW = 66,
    parameter int unsigned VCHW  = 2,
    parameter int unsigned PTRW  = 2
) (
    input logic             clk,
    input logic             rst_,
    noc_rr_pkt_mux_if.slave bus
`ifdef NOC_MUX_STATS_EN
    ,
    output logic [31:0]     oflit_cnt,
    output logic [31:0]     opkt_cnt
`endif
);

    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeData = 2'b10;
    localparam logic [1:0] TypeTail = 2'b11;

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e            state_q, state_d;
    logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]   owner_q, owner_d;
    logic [PTRW-1:0]   winner, sel;
    logic              win_valid, sel_act, out_free, xfer;
    logic [NPORT-1:0]  grant, iready;
    logic [DATAW-1:0]  sel_data, odata_q;
    logic [VCHW-1:0]   sel_vch, ovch_q;
    logic [1:0]        sel_type;
    logic              ovalid_q;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(NPORT - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // First requesting port scanning rr_ptr, rr_ptr+1, ... modulo NPORT.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            for (int unsigned k = 0; k < NPORT; k++) begin
                if (!win_valid && bus.ivalid[k] && (k == (32'(rr_ptr_q) + i) % NPORT)) begin
                    winner    = PTRW'(k);
                    win_valid = 1'b1;
                end
            end
        end
    end

    assign sel      = (state_q == StLock) ? owner_q : winner;
    assign sel_act  = (state_q == StLock) | win_valid;
    assign out_free = ~ovalid_q | bus.oready;

    // grant/iready are forced low during reset; iready never looks at the same port's ivalid.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        sel_vch  = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            grant[k] = rst_ & sel_act & (PTRW'(k) == sel);
            if (PTRW'(k) == sel) begin
                sel_data = bus.idata[k*DATAW +: DATAW];
                sel_vch  = bus.ivch[k*VCHW +: VCHW];
            end
        end
    end

    assign iready   = grant & {NPORT{out_free}};
    assign xfer     = |(bus.ivalid & iready);
    assign sel_type = sel_data[DATAW-1 -: 2];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (sel_type == TypeTail) begin
                        rr_ptr_d = ptr_inc(winner);
                    end else if (sel_type == TypeHead || sel_type == TypeData) begin
                        state_d = StLock;
                        owner_d = winner;
                    end
                end
            end
            StLock: begin
                // Only the owner can transfer here; a bubble simply holds the lock.
                if (xfer && sel_type == TypeTail) begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_inc(owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Output stage: load on transfer, clear valid once drained, hold everything while stalled.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata_q  <= '0;
            ovch_q   <= '0;
            ovalid_q <= 1'b0;
        end else if (xfer) begin
            odata_q  <= sel_data;
            ovch_q   <= sel_vch;
            ovalid_q <= 1'b1;
        end else if (bus.oready) begin
            ovalid_q <= 1'b0;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovch   = ovch_q;
    assign bus.ovalid = ovalid_q;
    assign bus.grant  = grant;
    assign bus.iready = iready;
    assign bus.locked = (state_q == StLock);

`ifdef NOC_MUX_STATS_EN
    logic out_hs;
    assign out_hs = ovalid_q & bus.oready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            oflit_cnt <= '0;
            opkt_cnt  <= '0;
        end else if (out_hs) begin
            oflit_cnt <= oflit_cnt + 32'd1;
            if (odata_q[DATAW-1 -: 2] == TypeTail) begin
                opkt_cnt <= opkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/noc_rr_pkt_mux.md
Name: noc_rr_pkt_mux

Overview:
- Parametrised N:1 packet-aware output multiplexer for the router output stage.
- Successor of the 2:1 combinational port mux.
- Round-robin arbitration among NPORT inputs, wormhole-locked from grant until the TAIL flit is accepted.
- Registered output with ready/valid backpressure; per-input ready returned to the upstream buffers.

Parameters:
- NPORT, 4, number of input ports (2..8).
- DATAW, 66, flit width including the 2-bit type field in bits [DATAW-1:DATAW-2].
- VCHW, 2, virtual-channel id width.
- PTRW, 2, width of the round-robin pointer (ceil log2 NPORT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- idata  in  NPORT*DATAW  flattened input flits; port k at [k*DATAW +: DATAW].
- ivalid  in  NPORT  per-port flit valid.
- ivch  in  NPORT*VCHW  per-port VC id, flattened the same way as idata.
- iready  out  NPORT  per-port accept; a flit transfers when ivalid[k] & iready[k].
- odata  out  DATAW  registered output flit.
- ovalid  out  1  registered output valid.
- ovch  out  VCHW  registered output VC id.
- oready  in  1  downstream accept.
- grant  out  NPORT  one-hot current owner/winner; all zero when nobody is selected.
- locked  out  1  high while a packet owns the output (state LOCK).

Behaviour:
- Clock and reset: one clock, clk; reset rst_ is asynchronous and active-low.
- Reset values: ovalid=0, odata=0, ovch=0, state=IDLE, rr_ptr=0, owner=0, locked=0. All outputs are 0 while rst_=0, including grant and iready.
- Type encoding: 2'b00 NONE, 2'b01 HEAD, 2'b10 DATA, 2'b11 TAIL.
- States: IDLE, LOCK.
- IDLE arbitration: the winner is the first port with ivalid=1 scanning rr_ptr, rr_ptr+1, ... modulo NPORT. grant is combinational.
- IDLE transfer: the winner's flit transfers this cycle if out_free = (~ovalid | oready).
  - Transferred HEAD or DATA: go to LOCK with owner = winner.
  - Transferred TAIL (single-flit packet): stay IDLE; rr_ptr <= winner+1 modulo NPORT.
- LOCK: grant = onehot(owner); other ports' iready=0 regardless of ivalid.
  - When the owner's TAIL transfers: IDLE and rr_ptr <= owner+1 modulo NPORT.
  - owner ivalid=0 mid-packet (bubble): hold LOCK indefinitely, ovalid drops after drain.
- iready[k] = grant[k] & out_free & rst_. iready never depends on ivalid[k] of the same port, so there is no combinational loop.
- Output register, latency 1 cycle:
  - On transfer: odata<=flit, ovch<=vch, ovalid<=1.
  - Else if oready: ovalid<=0; odata and ovch hold.
  - ovalid=1 & oready=0: odata, ovch, ovalid hold stable (no change while stalled).
- Throughput: 1 flit per cycle when oready stays high.
- NONE-type flits with ivalid=1 are forwarded like DATA and do not change state.
- Wrap-around: rr_ptr=NPORT-1 and a winner at port NPORT-1 gives next rr_ptr=0.
- Simultaneous events: a tail transfer and a new request in the same cycle means the new arbitration happens next cycle; no same-cycle regrant.
- Reset mid-packet: immediate return to IDLE, ovalid=0; the partial packet is discarded, with no recovery expected.

Optional Feature:
- Macro: NOC_MUX_STATS_EN.
- Defined: adds outputs oflit_cnt[31:0] and opkt_cnt[31:0].
  - oflit_cnt increments on every output handshake (ovalid & oready).
  - opkt_cnt increments on each handshake of a TAIL flit.
  - Both reset to 0 asynchronously and wrap at 2^32-1 -> 0.
- Not defined: the ports do not exist and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset check: hold rst_=0 with ivalid=4'b1111 -> ovalid=0, odata=0, iready=0, grant=0, locked=0. Release rst_ mid-cycle -> port 0 is granted on the next rising edge.
- Single-port packet, port 2: HEAD + 20 DATA + TAIL with oready=1 -> odata follows idata_2 one cycle later; 22 consecutive ovalid cycles; locked=1 from the HEAD edge until the TAIL edge.
- Round-robin order: ports 0, 1, 3 all present 3-flit packets at once -> output order is port 0, port 1, port 3, then port 0 again if it re-requests. rr_ptr wraps from 3 to 0.
- Lock under contention: port 1 mid-packet while port 0 asserts HEAD -> iready[0]=0 until port 1's TAIL transfers. Port 0's HEAD appears at the output no earlier than 1 cycle after port 1's TAIL.
- Backpressure: oready=0 for 5 cycles during DATA flit 7 -> odata holds flit 7 stable, iready[owner]=0, and no flit is lost or duplicated after oready returns.
- With NOC_MUX_STATS_EN: send 10 packets of 22 flits -> oflit_cnt=220 and opkt_cnt=10.
